// File: rtl/t08_lcd_ctrl.sv
// LCD command sequencer: plays the power-up script, then turns rectangle-fill
// requests into CASET/PASET/RAMWR plus one memory-write-continue per pixel.
module t08_lcd_ctrl #(
  parameter logic [23:0] RST_DELAY = 24'd120000,
  parameter logic [15:0] MAX_X     = 16'd240,
  parameter logic [15:0] MAX_Y     = 16'd320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_req,
  input  logic [15:0] fill_x0,
  input  logic [15:0] fill_x1,
  input  logic [15:0] fill_y0,
  input  logic [15:0] fill_y1,
  input  logic [15:0] fill_color,
  output logic        fill_ack,
  output logic        fill_err,
  output logic        fill_done,
  output logic        ready,
  output logic        init_done,
  output logic [7:0]  spi_command,
  output logic [31:0] spi_parameters,
  output logic [3:0]  spi_counter,
  output logic        spi_readwrite,
  output logic        spi_enable,
  input  logic        spi_busy
);

  typedef enum logic [2:0] {S_INIT, S_DELAY, S_IDLE, S_CASET, S_PASET, S_RAMWR, S_PIXEL} state_t;
  typedef enum logic [1:0] {X_IDLE, X_START, X_WAIT, X_GAP} xact_t;

  state_t      st, st_n;
  xact_t       xs, xs_n;
  logic [2:0]  step, step_n;
  logic [23:0] dly, dly_n;
  logic [31:0] pix, pix_n;
  logic [15:0] x0_q, x1_q, y0_q, y1_q, col_q;
  logic        latch, ack_n, err_n, done_n, init_n;
  logic        req_ok;
  logic [31:0] area;
  logic [7:0]  cmd_c;
  logic [31:0] par_c;
  logic [3:0]  cnt_c;

  assign req_ok = (fill_x0 <= fill_x1) && (fill_x1 < MAX_X) &&
                  (fill_y0 <= fill_y1) && (fill_y1 < MAX_Y);
  assign area   = ({16'd0, fill_x1 - fill_x0} + 32'd1) * ({16'd0, fill_y1 - fill_y0} + 32'd1);

  assign ready         = (st == S_IDLE) && init_done;
  assign spi_readwrite = 1'b1;
  assign spi_enable    = (xs == X_START) || (xs == X_WAIT);

  // Command word is a pure function of the calling state; it is zero
  // whenever no transaction is in flight.
  always_comb begin
    cmd_c = 8'h00;
    par_c = 32'h0;
    cnt_c = 4'd0;
    case (st)
      S_INIT: begin
        case (step)
          3'd0:    cmd_c = 8'h01;
          3'd1:    cmd_c = 8'h28;
          3'd2:    begin cmd_c = 8'h3A; par_c = 32'h5500_0000; cnt_c = 4'd1; end
          3'd3:    cmd_c = 8'h11;
          default: cmd_c = 8'h29;
        endcase
      end
      S_CASET: begin cmd_c = 8'h2A; par_c = {x0_q, x1_q};    cnt_c = 4'd4; end
      S_PASET: begin cmd_c = 8'h2B; par_c = {y0_q, y1_q};    cnt_c = 4'd4; end
      S_RAMWR: begin cmd_c = 8'h2C; par_c = {col_q, col_q};  cnt_c = 4'd3; end
      S_PIXEL: begin cmd_c = 8'h3C; par_c = {col_q, 16'h0}; cnt_c = 4'd2; end
      default: ;
    endcase
  end

  assign spi_command    = (xs == X_IDLE) ? 8'h00  : cmd_c;
  assign spi_parameters = (xs == X_IDLE) ? 32'h0  : par_c;
  assign spi_counter    = (xs == X_IDLE) ? 4'd0   : cnt_c;

  always_comb begin
    st_n   = st;
    xs_n   = xs;
    step_n = step;
    dly_n  = dly;
    pix_n  = pix;
    latch  = 1'b0;
    ack_n  = 1'b0;
    err_n  = 1'b0;
    done_n = 1'b0;
    init_n = init_done;
    case (xs)
      X_START: if (spi_busy)  xs_n = X_WAIT;
      X_WAIT:  if (!spi_busy) xs_n = X_GAP;
      X_GAP: begin
        xs_n = X_IDLE;
        case (st)
          S_INIT: begin
            step_n = step + 3'd1;
            if (step == 3'd0 || step == 3'd3) begin
              st_n  = S_DELAY;
              dly_n = '0;
            end else if (step == 3'd4) begin
              st_n   = S_IDLE;
              step_n = step;
              init_n = 1'b1;
            end else begin
              xs_n = X_START;
            end
          end
          S_CASET: begin st_n = S_PASET; xs_n = X_START; end
          S_PASET: begin st_n = S_RAMWR; xs_n = X_START; end
          S_RAMWR: begin st_n = S_PIXEL; xs_n = X_START; end
          S_PIXEL: begin
            pix_n = pix - 32'd1;
            if (pix == 32'd1) begin
              st_n   = S_IDLE;
              done_n = 1'b1;
            end else begin
              xs_n = X_START;
            end
          end
          default: ;
        endcase
      end
      default: begin
        case (st)
          S_INIT: xs_n = X_START;
          S_DELAY: begin
            if (dly == RST_DELAY - 24'd1) begin
              st_n  = S_INIT;
              xs_n  = X_START;
              dly_n = '0;
            end else begin
              dly_n = dly + 24'd1;
            end
          end
          // An error pulse blocks re-evaluation so a requester dropping
          // fill_req on seeing it does not get a second pulse.
          S_IDLE: begin
            if (fill_req && init_done && !fill_err) begin
              if (req_ok) begin
                ack_n = 1'b1;
                latch = 1'b1;
                pix_n = area;
                st_n  = S_CASET;
                xs_n  = X_START;
              end else begin
                err_n = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_INIT;
      xs        <= X_IDLE;
      step      <= 3'd0;
      dly       <= '0;
      pix       <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      col_q     <= '0;
      fill_ack  <= 1'b0;
      fill_err  <= 1'b0;
      fill_done <= 1'b0;
      init_done <= 1'b0;
    end else begin
      st        <= st_n;
      xs        <= xs_n;
      step      <= step_n;
      dly       <= dly_n;
      pix       <= pix_n;
      fill_ack  <= ack_n;
      fill_err  <= err_n;
      fill_done <= done_n;
      init_done <= init_n;
      if (latch) begin
        x0_q  <= fill_x0;
        x1_q  <= fill_x1;
        y0_q  <= fill_y0;
        y1_q  <= fill_y1;
        col_q <= fill_color;
      end
    end
  end

endmodule

// File: doc/t08_lcd_ctrl.md
Name: t08_lcd_ctrl

Overview:
- Sequencer that drives the team's 8080-style LCD SPI transmitter: command byte, 32-bit parameter word, parameter count, enable/busy handshake.
- After reset it plays a fixed ILI9341-class power-up sequence.
- It then serves rectangle-fill requests: CASET, then PASET, then RAMWR, then one memory-write-continue transaction per pixel.
- It sits between the application logic and the transmitter, and is that transmitter's only master.

Parameters:
- RST_DELAY, 24'd120000: idle cycles after SWRESET and after SLPOUT.
- MAX_X, 16'd240: column limit, exclusive.
- MAX_Y, 16'd320: page limit, exclusive.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- fill_req  in  1  fill request; level, held until fill_ack or fill_err
- fill_x0  in  16  start column
- fill_x1  in  16  end column, inclusive
- fill_y0  in  16  start page
- fill_y1  in  16  end page, inclusive
- fill_color  in  16  RGB565 pixel value
- fill_ack  out  1  one-cycle pulse: request accepted, inputs latched
- fill_err  out  1  one-cycle pulse: request rejected
- fill_done  out  1  one-cycle pulse: last pixel transaction complete
- ready  out  1  idle and init complete; a request can be accepted this cycle
- init_done  out  1  high once the power-up sequence finishes
- spi_command  out  8  command byte to transmitter
- spi_parameters  out  32  parameter word, MSB byte sent first
- spi_counter  out  4  parameter count for non-table commands
- spi_readwrite  out  1  always 1 (write)
- spi_enable  out  1  transaction enable
- spi_busy  in  1  transmitter busy

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - All outputs go to 0 except spi_readwrite=1.
  - State goes to INIT, step 0.
  - Delay counter and pixel counter clear.
  - Applies mid-transaction: spi_enable drops on the same edge and the init sequence restarts.
- Transaction sub-FSM, used by every command:
  - XSTART: spi_command/spi_parameters/spi_counter stable; spi_enable=1; stay until spi_busy=1.
  - XWAIT: spi_enable=1; stay until spi_busy=0.
  - XGAP: spi_enable=0 for exactly 1 cycle, which returns the transmitter to idle; then return to the calling state.
  - Command/parameter outputs stay stable from XSTART through XWAIT.
- Init sequence (INIT, then IDLE):
  1. 0x01 SWRESET, count 0, then DELAY of RST_DELAY cycles.
  2. 0x28 DISPOFF, count 0.
  3. 0x3A COLMOD, parameters 0x55000000, count 1.
  4. 0x11 SLPOUT, count 0, then DELAY of RST_DELAY cycles.
  5. 0x29 DISPON, count 0.
  - After step 5's XGAP: init_done=1 (sticky until rst); go to IDLE.
- IDLE:
  - ready=1 only in IDLE with init_done=1.
  - fill_req is ignored while ready=0.
- Request check, on fill_req=1 in IDLE:
  - Valid when x0<=x1<MAX_X and y0<=y1<MAX_Y.
  - Valid: pulse fill_ack; latch the coordinates and colour; pixel count = (x1-x0+1)*(y1-y0+1), 32-bit unsigned; go to CASET.
  - Invalid: pulse fill_err, stay in IDLE, no SPI activity.
- Fill sequence:
  - CASET: 0x2A, parameters {x0,x1}.
  - PASET: 0x2B, parameters {y0,y1}.
  - RAMWR: 0x2C with parameters {colour,colour}. The transmitter's fixed count of 3 bytes sends the first pixel plus the upper colour byte. This is accepted; RAMWR does not decrement the pixel counter.
  - PIXEL: 0x3C, count 2, parameters {colour,16'h0}; decrement the pixel counter after each XGAP; repeat while the counter is nonzero.
  - After the final PIXEL XGAP: pulse fill_done in the same cycle ready rises; go to IDLE.
- Boundary cases:
  - A 1x1 rectangle still issues exactly 1 PIXEL transaction.
  - Full-screen fill: 76800 PIXEL transactions with no counter overflow.
  - fill_req held high across fill_done: a new accept happens no earlier than the cycle after fill_done.
  - spi_busy already 1 on XSTART entry: advance to XWAIT next cycle.
  - No timeout; a stuck transmitter hangs until rst.
- Latency: accept-to-first spi_enable is 1 cycle. Each transaction takes 3 controller cycles plus transmitter busy time.

Test Plan:
- Reset then free-run, RST_DELAY=16 in bench: command sequence 01,28,3A(0x55000000),11,29 in order; the 16-cycle gaps follow 01 and 11; init_done rises after the 29 XGAP; no fill_ack before that.
- Fill (2,3,4,4), colour 0xF800: fill_ack once; transactions 2A{0002,0003}, 2B{0004,0004}, 2C{F800F800}, then exactly 2 of 3C{F8000000}; fill_done once; ready=1 after.
- Invalid requests, x0=5,x1=4 and x1=240: fill_err pulse, no spi_enable edge, ready stays 1.
- fill_req asserted during init and during an active fill: no ack until ready=1; then exactly one ack per held request.
- rst asserted mid-PIXEL with spi_busy=1: next cycle spi_enable=0, init_done=0, ready=0; the sequence restarts with 0x01.
- Transmitter model with 0-cycle and 5-cycle busy delays: spi_enable low for exactly 1 cycle between transactions; outputs stable while spi_enable=1.
